a0_trace_fifo: RTL

Downstream consumer of the CPU core's a0 output. It samples a0 every cycle and detects changes. Each change is pushed, with a cycle timestamp, into a small FIFO. Entries drain over a valid/ready interface to the display/trace sink, so every register-a0 update survives sink back-pressure or is counted as lost.

---
 rtl/a0_trace_fifo.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/a0_trace_fifo.sv
// Captures every change of the core's a0 register with a cycle timestamp and
// drains the events over a first-word fall-through valid/ready interface.
module a0_trace_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int CYCLE_WIDTH = 32,
    parameter int DROP_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    a0_in,
    input  logic                     capture_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [CYCLE_WIDTH-1:0]   out_cycle,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [DROP_WIDTH-1:0]    drop_cnt,
    output logic                     drop_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [CYCLE_WIDTH-1:0] cyc_q;
    logic [DROP_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
    logic                   drop_flag_q, drop_flag_d;
    logic                   prev_valid_q, prev_valid_d;
    logic [DATA_WIDTH-1:0]  prev_q, prev_d;

    logic [DATA_WIDTH-1:0]  data_mem_q [DEPTH];
    logic [CYCLE_WIDTH-1:0] cyc_mem_q  [DEPTH];

    logic full_s, empty_s, event_s, pop_s, push_s, drop_s;

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == {CW{1'b0}});

    // Event detection and push/pop/drop arbitration.
    always_comb begin
        event_s = 1'b0;
        pop_s   = 1'b0;
        push_s  = 1'b0;
        drop_s  = 1'b0;
        if (capture_en) begin
            event_s = !prev_valid_q || (a0_in != prev_q);
        end else begin
            event_s = 1'b0;
        end
        pop_s  = !empty_s && out_ready;
        push_s = event_s && (!full_s || pop_s);
        drop_s = event_s && full_s && !pop_s;
    end

    // Next-state values for pointers, occupancy, change tracking and drop accounting.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_cnt_d   = drop_cnt_q;
        drop_flag_d  = drop_flag_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        // The drop counter saturates so a long stall never makes it look healthy.
        if (drop_s && (drop_cnt_q != {DROP_WIDTH{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + {{(DROP_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        if (drop_s) begin
            drop_flag_d = 1'b1;
        end else begin
            drop_flag_d = drop_flag_q;
        end

        if (capture_en) begin
            prev_d       = a0_in;
            prev_valid_d = 1'b1;
        end else begin
            prev_d       = prev_q;
            prev_valid_d = prev_valid_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            cyc_q        <= {CYCLE_WIDTH{1'b0}};
            drop_cnt_q   <= {DROP_WIDTH{1'b0}};
            drop_flag_q  <= 1'b0;
            prev_q       <= {DATA_WIDTH{1'b0}};
            prev_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            cyc_q        <= cyc_q + {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};
            drop_cnt_q   <= drop_cnt_d;
            drop_flag_q  <= drop_flag_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            data_mem_q[wr_ptr_q] <= a0_in;
            cyc_mem_q[wr_ptr_q]  <= cyc_q;
        end
    end

    assign out_valid = !empty_s;
    assign out_data  = empty_s ? {DATA_WIDTH{1'b0}}  : data_mem_q[rd_ptr_q];
    assign out_cycle = empty_s ? {CYCLE_WIDTH{1'b0}} : cyc_mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = full_s;
    assign empty     = empty_s;
    assign drop_cnt  = drop_cnt_q;
    assign drop_flag = drop_flag_q;

endmodule
